// File: rtl/puf_scan_chain_emulator.sv
`default_nettype none
// ============================================================================
// Module   : puf_scan_chain_emulator
// Purpose  : Device-side PUF scan chain model (challenge in, evaluate, 4x128b
//            response out) driven by host PH1/PH2/Trig sampled in clk domain.
//            Optional LFSR response noise: define PUF_EMU_NOISE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module puf_scan_chain_emulator #(
    parameter logic [127:0] KEY_UP      = 128'h0,
    parameter logic [127:0] KEY_DOWN    = 128'h0,
    parameter int unsigned  EVAL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic PH1,
    input  logic PH2,
    input  logic CA_SI,
    input  logic CB_SI,
    input  logic Ph_En,
    input  logic OutEn,
    input  logic Trig,
    input  logic SO_Up_In,
    input  logic SO_not_Up_In,
    input  logic SO_Down_In,
    input  logic SO_not_Down_In,
    output logic SO_Up,
    output logic SO_not_Up,
    output logic SO_Down,
    output logic SO_not_Down,
    output logic CAout,
    output logic CBout,
    output logic phase_err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EVAL   = 2'd1,
        S_READY  = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    localparam logic [2:0] EVAL_LAST = 3'(EVAL_CYCLES - 1);

    state_t       state_q, state_d;
    logic         ph1_q, ph1_d, ph2_q, ph2_d, trig_q, trig_d;
    logic         phase_err_q, phase_err_d;
    logic         armed_q, armed_d;
    logic [7:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]   eval_cnt_q, eval_cnt_d;
    logic [127:0] ca_q, ca_d, cb_q, cb_d;
    logic [127:0] up_q, up_d, up_n_q, up_n_d;
    logic [127:0] dn_q, dn_d, dn_n_q, dn_n_d;

    logic         ph1_rise, trig_rise;
    logic [127:0] up_eval, dn_eval, flip_mask;

    assign ph1_rise  = PH1 & ~ph1_q;
    assign trig_rise = Trig & ~trig_q;
    assign up_eval   = ca_q ^ cb_q ^ KEY_UP;
    assign dn_eval   = ca_q ^ {cb_q[0], cb_q[127:1]} ^ KEY_DOWN;

`ifdef PUF_EMU_NOISE_EN
    logic [15:0] lfsr_q, lfsr_d, lfsr_next;
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Same bit flipped in up and up_n so the pair stays complementary
    assign flip_mask = 128'd1 << lfsr_next[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lfsr_q <= 16'hACE1;
        else     lfsr_q <= lfsr_d;
    end
`else
    assign flip_mask = '0;
`endif

    always_comb begin
        state_d     = state_q;
        ph1_d       = PH1;
        ph2_d       = PH2;
        trig_d      = Trig;
        phase_err_d = phase_err_q | (ph1_q & ph2_q);
        armed_d     = armed_q;
        bit_cnt_d   = bit_cnt_q;
        eval_cnt_d  = eval_cnt_q;
        ca_d        = ca_q;
        cb_d        = cb_q;
        up_d        = up_q;
        up_n_d      = up_n_q;
        dn_d        = dn_q;
        dn_n_d      = dn_n_q;
`ifdef PUF_EMU_NOISE_EN
        lfsr_d      = lfsr_q;
`endif
        case (state_q)
            S_IDLE, S_READY: begin
                if (ph1_rise) begin
                    if (!Ph_En) begin
                        bit_cnt_d = 8'd0;
                    end else if (bit_cnt_q < 8'd128) begin
                        ca_d      = {CA_SI, ca_q[127:1]};
                        cb_d      = {CB_SI, cb_q[127:1]};
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
                if (trig_rise) begin
                    state_d    = S_EVAL;
                    eval_cnt_d = 3'd0;
                end else if (state_q == S_READY && ph1_rise && OutEn) begin
                    // Arming phase: bit 0 is already on SO, so nothing shifts yet
                    state_d = S_UNLOAD;
                    armed_d = 1'b1;
                end
            end
            S_EVAL: begin
                if (eval_cnt_q == EVAL_LAST) begin
                    up_d    = up_eval ^ flip_mask;
                    up_n_d  = ~(up_eval ^ flip_mask);
                    dn_d    = dn_eval;
                    dn_n_d  = ~dn_eval;
                    state_d = S_READY;
`ifdef PUF_EMU_NOISE_EN
                    lfsr_d  = lfsr_next;
`endif
                end else begin
                    eval_cnt_d = eval_cnt_q + 3'd1;
                end
            end
            S_UNLOAD: begin
                if (ph1_rise) begin
                    if (OutEn && armed_q) begin
                        up_d   = {SO_Up_In, up_q[127:1]};
                        up_n_d = {SO_not_Up_In, up_n_q[127:1]};
                        dn_d   = {SO_Down_In, dn_q[127:1]};
                        dn_n_d = {SO_not_Down_In, dn_n_q[127:1]};
                        ca_d   = {1'b0, ca_q[127:1]};
                        cb_d   = {1'b0, cb_q[127:1]};
                    end else if (!OutEn) begin
                        state_d = S_IDLE;
                        armed_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ph1_q       <= 1'b0;
            ph2_q       <= 1'b0;
            trig_q      <= 1'b0;
            phase_err_q <= 1'b0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 8'd0;
            eval_cnt_q  <= 3'd0;
            ca_q        <= '0;
            cb_q        <= '0;
            up_q        <= '0;
            up_n_q      <= '0;
            dn_q        <= '0;
            dn_n_q      <= '0;
        end else begin
            state_q     <= state_d;
            ph1_q       <= ph1_d;
            ph2_q       <= ph2_d;
            trig_q      <= trig_d;
            phase_err_q <= phase_err_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            eval_cnt_q  <= eval_cnt_d;
            ca_q        <= ca_d;
            cb_q        <= cb_d;
            up_q        <= up_d;
            up_n_q      <= up_n_d;
            dn_q        <= dn_d;
            dn_n_q      <= dn_n_d;
        end
    end

    assign SO_Up       = up_q[0];
    assign SO_not_Up   = up_n_q[0];
    assign SO_Down     = dn_q[0];
    assign SO_not_Down = dn_n_q[0];
    assign CAout       = ca_q[0];
    assign CBout       = cb_q[0];
    assign phase_err   = phase_err_q;

endmodule
`default_nettype wire

// File: tb/tb_puf_scan_chain_emulator.sv
`default_nettype none
// Directed bench for puf_scan_chain_emulator: two instances (default keys,
// nonzero keys) driven by a host-like PH1 sequencer.
`timescale 1ns/1ps
module tb_puf_scan_chain_emulator;

    localparam logic [127:0] K1_UP = 128'hFFFF;
    localparam logic [127:0] K1_DN = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    logic clk = 1'b0;
    logic rst, PH1, PH2, CA_SI, CB_SI, Ph_En, OutEn, Trig;
    logic up_in, upn_in, dn_in, dnn_in;
    logic so_up0, so_upn0, so_dn0, so_dnn0, ca_o0, cb_o0, perr0;
    logic so_up1, so_upn1, so_dn1, so_dnn1, ca_o1, cb_o1, perr1;

    int checks   = 0;
    int failures = 0;

    logic [127:0] r_up0, r_upn0, r_dn0, r_dnn0, r_ca, r_cb;
    logic [127:0] r_up1, r_upn1, r_dn1, r_dnn1;
    logic [127:0] e_up0, e_dn0, e_up1, e_dn1;
    logic [3:0]   r_fill;
    logic [127:0] va, vb;
`ifdef PUF_EMU_NOISE_EN
    logic [15:0]  m_lfsr;
`endif

    puf_scan_chain_emulator u_dut0 (
        .clk(clk), .rst(rst), .PH1(PH1), .PH2(PH2), .CA_SI(CA_SI), .CB_SI(CB_SI),
        .Ph_En(Ph_En), .OutEn(OutEn), .Trig(Trig),
        .SO_Up_In(up_in), .SO_not_Up_In(upn_in), .SO_Down_In(dn_in), .SO_not_Down_In(dnn_in),
        .SO_Up(so_up0), .SO_not_Up(so_upn0), .SO_Down(so_dn0), .SO_not_Down(so_dnn0),
        .CAout(ca_o0), .CBout(cb_o0), .phase_err(perr0)
    );

    puf_scan_chain_emulator #(.KEY_UP(K1_UP), .KEY_DOWN(K1_DN), .EVAL_CYCLES(8)) u_dut1 (
        .clk(clk), .rst(rst), .PH1(PH1), .PH2(PH2), .CA_SI(CA_SI), .CB_SI(CB_SI),
        .Ph_En(Ph_En), .OutEn(OutEn), .Trig(Trig),
        .SO_Up_In(up_in), .SO_not_Up_In(upn_in), .SO_Down_In(dn_in), .SO_not_Down_In(dnn_in),
        .SO_Up(so_up1), .SO_not_Up(so_upn1), .SO_Down(so_dn1), .SO_not_Down(so_dnn1),
        .CAout(ca_o1), .CBout(cb_o1), .phase_err(perr1)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
`ifdef PUF_EMU_NOISE_EN
        m_lfsr = 16'hACE1;
`endif
    endtask

    // One host PH1 phase: inputs stable across the edge where the rise is seen
    task automatic pulse(input logic ca_bit, input logic cb_bit, input logic en, input logic oen);
        CA_SI = ca_bit;
        CB_SI = cb_bit;
        Ph_En = en;
        OutEn = oen;
        PH1   = 1'b1;
        tick();
        PH1   = 1'b0;
        tick();
        tick();
    endtask

    task automatic load(input logic [127:0] a, input logic [127:0] b);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 128; i++) pulse(a[i], b[i], 1'b1, 1'b0);
    endtask

    task automatic model_eval(input logic [127:0] a, input logic [127:0] b);
        logic [127:0] flip;
        flip = '0;
`ifdef PUF_EMU_NOISE_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        flip[m_lfsr[6:0]] = 1'b1;
`endif
        e_up0 = a ^ b ^ flip;
        e_dn0 = a ^ {b[0], b[127:1]};
        e_up1 = a ^ b ^ K1_UP ^ flip;
        e_dn1 = a ^ {b[0], b[127:1]} ^ K1_DN;
    endtask

    task automatic evaluate(input logic [127:0] a, input logic [127:0] b);
        Trig = 1'b1;
        repeat (12) tick();
        Trig = 1'b0;
        tick();
        model_eval(a, b);
    endtask

    // Arm, then read bit k before shift k; trig_at pulses Trig mid-readout
    task automatic unload(input int trig_at);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 128; k++) begin
            r_up0[k] = so_up0;  r_upn0[k] = so_upn0; r_dn0[k] = so_dn0; r_dnn0[k] = so_dnn0;
            r_up1[k] = so_up1;  r_upn1[k] = so_upn1; r_dn1[k] = so_dn1; r_dnn1[k] = so_dnn1;
            r_ca[k]  = ca_o0;   r_cb[k]   = cb_o0;
            if (k == trig_at) Trig = 1'b1;
            pulse(1'b0, 1'b0, 1'b0, 1'b1);
            Trig = 1'b0;
        end
        r_fill = {so_up0, so_upn0, so_dn0, so_dnn0};
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_streams(input string tag, input logic [127:0] a, input logic [127:0] b);
        chk({tag, "_up0"},  r_up0,  e_up0);
        chk({tag, "_upn0"}, r_upn0, ~e_up0);
        chk({tag, "_dn0"},  r_dn0,  e_dn0);
        chk({tag, "_dnn0"}, r_dnn0, ~e_dn0);
        chk({tag, "_up1"},  r_up1,  e_up1);
        chk({tag, "_upn1"}, r_upn1, ~e_up1);
        chk({tag, "_dn1"},  r_dn1,  e_dn1);
        chk({tag, "_dnn1"}, r_dnn1, ~e_dn1);
        chk({tag, "_ca"},   r_ca,   a);
        chk({tag, "_cb"},   r_cb,   b);
        chk({tag, "_fill"}, 128'(r_fill), 128'(4'b1011));
    endtask

    initial begin
        rst = 1'b1; PH1 = 1'b0; PH2 = 1'b0; CA_SI = 1'b0; CB_SI = 1'b0;
        Ph_En = 1'b0; OutEn = 1'b0; Trig = 1'b0;
        up_in = 1'b1; upn_in = 1'b0; dn_in = 1'b1; dnn_in = 1'b1;
        do_reset();

        chk("rst_so0",   128'({so_up0, so_upn0, so_dn0, so_dnn0}), 128'd0);
        chk("rst_cab0",  128'({ca_o0, cb_o0, perr0}), 128'd0);
        chk("rst_so1",   128'({so_up1, so_upn1, so_dn1, so_dnn1, ca_o1, cb_o1, perr1}), 128'd0);

        // Defaults: ca=1, cb=0
        load(128'h1, 128'h0);
        evaluate(128'h1, 128'h0);
        unload(-1);
        check_streams("dflt", 128'h1, 128'h0);
`ifndef PUF_EMU_NOISE_EN
        chk("dflt_up0_lit", r_up0, 128'h1);
        chk("dflt_dn0_lit", r_dn0, 128'h1);
`endif

        // Keys with equal challenges; Trig mid-readout must be ignored
        load(128'hA5A5, 128'hA5A5);
        evaluate(128'hA5A5, 128'hA5A5);
        unload(50);
        check_streams("key", 128'hA5A5, 128'hA5A5);
`ifndef PUF_EMU_NOISE_EN
        chk("key_up1_lit",  r_up1,  128'hFFFF);
        chk("key_upn1_lit", r_upn1, ~128'hFFFF);
`endif

        // Saturation: 129th enabled phase carries X and must be dropped
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        load(va, vb);
        pulse(1'bx, 1'bx, 1'b1, 1'b0);
        evaluate(va, vb);
        unload(-1);
        check_streams("sat", va, vb);

        // Async reset mid-UNLOAD
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        load(va, vb);
        evaluate(va, vb);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (40) pulse(1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out0", 128'({so_up0, so_upn0, so_dn0, so_dnn0, ca_o0, cb_o0}), 128'd0);
        chk("midrst_out1", 128'({so_up1, so_upn1, so_dn1, so_dnn1, ca_o1, cb_o1}), 128'd0);
        OutEn = 1'b0;
        do_reset();
        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        load(va, vb);
        evaluate(va, vb);
        unload(-1);
        check_streams("post", va, vb);

        // phase_err sticky until reset
        chk("perr_clear", 128'({perr0, perr1}), 128'd0);
        Ph_En = 1'b0;
        OutEn = 1'b0;
        PH1 = 1'b1;
        PH2 = 1'b1;
        tick();
        PH1 = 1'b0;
        PH2 = 1'b0;
        tick();
        tick();
        chk("perr_set", 128'({perr0, perr1}), 128'(2'b11));
        repeat (6) tick();
        chk("perr_sticky", 128'({perr0, perr1}), 128'(2'b11));
        do_reset();
        chk("perr_rst", 128'({perr0, perr1}), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
